// File: rtl/freq_power_optimizer.sv
// SWIPT link optimiser: hill-climbs the TX frequency on received power, locks, qualifies the lock, re-searches on a power drop.
// Outputs are registered (one-cycle response); meas_valid has no backpressure and strobes outside the sampling window are dropped.
module freq_power_optimizer #(
  parameter int                FREQ_W        = 20,
  parameter int                PWR_W         = 16,
  parameter logic [FREQ_W-1:0] FREQ_INIT     = 20'd100000,
  parameter logic [FREQ_W-1:0] FREQ_MIN      = 20'd50000,
  parameter logic [FREQ_W-1:0] FREQ_MAX      = 20'd200000,
  parameter int                STEP_INIT     = 50,
  parameter int                STEP_MIN      = 1,
  parameter int                SETTLE_CYCLES = 1000,
  parameter int                STABLE_CYCLES = 250000,
  parameter int                DROP_TH       = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              swiptAlive,
  input  logic              meas_valid,
  input  logic [PWR_W-1:0]  meas_power,
  output logic [FREQ_W-1:0] freq_new,
  output logic              freq_load,
  output logic [FREQ_W-1:0] best_freq,
  output logic [PWR_W-1:0]  best_power,
  output logic              freq_optimum,
  output logic              data_go,
  output logic              data_start
);
  localparam int SEW = $clog2(SETTLE_CYCLES + 1);
  localparam int STW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [FREQ_W-1:0] STEP_INIT_V = FREQ_W'(STEP_INIT);
  localparam logic [FREQ_W-1:0] STEP_MIN_V  = FREQ_W'(STEP_MIN);
  localparam logic [SEW-1:0]    SETTLE_V    = SEW'(SETTLE_CYCLES);
  localparam logic [STW-1:0]    STABLE_LD   = STW'(STABLE_CYCLES - 1);
  localparam logic [PWR_W:0]    DROP_V      = (PWR_W+1)'(DROP_TH);

  typedef enum logic [2:0] {IDLE, BASE, STEP, PROBE, LOCK, DATA} state_t;

  state_t            state;
  logic [FREQ_W-1:0] step_r;
  logic              dir_up;
  logic              rev_cnt;
  logic [SEW-1:0]    settle_cnt;
  logic [STW-1:0]    stable_cnt;

  logic              settle_done;
  logic              improve;
  logic              drop_trig;
  logic [FREQ_W-1:0] step_half;
  logic [FREQ_W-1:0] next_step;
  logic [FREQ_W:0]   cand_wide;
  logic [FREQ_W-1:0] cand_sat;

  assign settle_done = (settle_cnt == SETTLE_V);
  assign improve     = (meas_power > best_power) && (freq_new != best_freq);
  assign drop_trig   = ({1'b0, meas_power} + DROP_V) < {1'b0, best_power};
  assign step_half   = step_r >> 1;
  assign next_step   = (improve || !rev_cnt) ? step_r : step_half;

  // A downward step larger than best_freq borrows out of the wide word, so it is clamped explicitly.
  always_comb begin
    cand_wide = dir_up ? ({1'b0, best_freq} + {1'b0, step_r})
                       : ({1'b0, best_freq} - {1'b0, step_r});
    if (!dir_up && (step_r > best_freq))      cand_sat = FREQ_MIN;
    else if (cand_wide > {1'b0, FREQ_MAX})    cand_sat = FREQ_MAX;
    else if (cand_wide < {1'b0, FREQ_MIN})    cand_sat = FREQ_MIN;
    else                                      cand_sat = cand_wide[FREQ_W-1:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      freq_new     <= FREQ_INIT;
      best_freq    <= FREQ_INIT;
      best_power   <= '0;
      freq_load    <= 1'b0;
      freq_optimum <= 1'b0;
      data_go      <= 1'b0;
      data_start   <= 1'b0;
      step_r       <= STEP_INIT_V;
      dir_up       <= 1'b1;
      rev_cnt      <= 1'b0;
      settle_cnt   <= '0;
      stable_cnt   <= '0;
    end else begin
      freq_load <= 1'b0;
      if (!swiptAlive) begin
        state        <= IDLE;
        freq_optimum <= 1'b0;
        data_go      <= 1'b0;
        data_start   <= 1'b0;
        settle_cnt   <= '0;
        stable_cnt   <= '0;
        rev_cnt      <= 1'b0;
      end else begin
        if ((state == BASE || state == PROBE) && !settle_done)
          settle_cnt <= settle_cnt + 1'b1;
        case (state)
          IDLE: begin
            // Every fresh link restarts the search from scratch.
            state      <= BASE;
            freq_new   <= FREQ_INIT;
            freq_load  <= 1'b1;
            settle_cnt <= '0;
            step_r     <= STEP_INIT_V;
            dir_up     <= 1'b1;
            rev_cnt    <= 1'b0;
          end
          BASE: begin
            if (meas_valid && settle_done) begin
              best_power <= meas_power;
              best_freq  <= freq_new;
              state      <= STEP;
            end
          end
          STEP: begin
            freq_new   <= cand_sat;
            freq_load  <= 1'b1;
            settle_cnt <= '0;
            state      <= PROBE;
          end
          PROBE: begin
            if (meas_valid && settle_done) begin
              if (improve) begin
                best_freq  <= freq_new;
                best_power <= meas_power;
                rev_cnt    <= 1'b0;
              end else begin
                dir_up <= !dir_up;
                if (rev_cnt) begin
                  step_r  <= step_half;
                  rev_cnt <= 1'b0;
                end else begin
                  rev_cnt <= 1'b1;
                end
              end
              if (next_step < STEP_MIN_V) begin
                state        <= LOCK;
                freq_new     <= best_freq;
                freq_load    <= (freq_new != best_freq);
                freq_optimum <= 1'b1;
                data_go      <= 1'b1;
                stable_cnt   <= STABLE_LD;
              end else begin
                state <= STEP;
              end
            end
          end
          LOCK, DATA: begin
            if (meas_valid && drop_trig) begin
              freq_optimum <= 1'b0;
              data_go      <= 1'b0;
              data_start   <= 1'b0;
              best_power   <= meas_power;
              step_r       <= STEP_INIT_V;
              rev_cnt      <= 1'b0;
              dir_up       <= 1'b1;
              state        <= STEP;
            end else if (state == LOCK) begin
              if (stable_cnt == '0) begin
                state      <= DATA;
                data_start <= 1'b1;
              end else begin
                stable_cnt <= stable_cnt - 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
